inst_fetch_unit: RTL and testbench
==================================

Name: inst_fetch_unit

Overview:
- Fetch stage of the team RV32I core, directly upstream of decode and the immediate generator.
- Owns the PC and issues one-outstanding word reads to instruction memory over a req/ack handshake.
- Buffers up to 2 fetched words in a FIFO and presents them to decode with valid/ready.
- Accepts branch/jump redirects from execute and discards any in-flight stale data.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset (word aligned)
NOP_INST, 32'h0000_0013, value driven on inst when buffer empty (addi x0,x0,0)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
redirect_valid  input  1  execute requests PC change this cycle
redirect_pc  input  32  new fetch target
mem_req  output  1  read request to instruction memory
mem_addr  output  32  word address of request
mem_ack  input  1  one-cycle pulse, mem_rdata valid
mem_rdata  input  32  returned instruction word
inst_valid  output  1  buffer head valid
inst_ready  input  1  decode accepts head
inst  output  32  buffer head instruction (NOP_INST when empty)
inst_pc  output  32  PC of buffer head (0 when empty)
fetch_fault  output  1  misaligned-redirect fault (see Optional Feature)

Behaviour:
- Reset (rst=1 at edge): state=FETCH, pc=RESET_PC, FIFO count=0, fetch_fault=0. Outputs during and after reset: inst_valid=0, inst=NOP_INST, inst_pc=0, mem_addr=pc.
- States:
  - FETCH: request active.
  - HOLD: FIFO full, no request.
  - DROP: stale request outstanding.
  - HALT: optional feature only.
- mem_req = (state==FETCH || state==DROP). mem_addr = pc in FETCH, stale_addr in DROP.
- Request rule: once mem_req=1, mem_addr holds stable until the mem_ack cycle. The memory may take any number of cycles ≥1.
- First mem_req=1 occurs in the first cycle with rst=0.
- FETCH + mem_ack, no redirect:
  - push {pc, mem_rdata}; pc <= pc+4 (32-bit wrap; 0xFFFF_FFFC+4 = 0).
  - If count after push/pop == 2, go to HOLD. Otherwise stay in FETCH, and the next request issues in the following cycle (back-to-back, 1 word/cycle max).
- HOLD → FETCH in the cycle after a dequeue leaves count < 2.
- Dequeue: inst_valid=(count!=0). A pop occurs when inst_valid & inst_ready. Simultaneous push and pop in one cycle keeps count unchanged. The FIFO preserves order.
- inst and inst_pc are combinational from the FIFO head. Load-to-visible latency is 1 cycle after the mem_ack edge.
- Redirect (priority over everything):
  - FIFO flushed to count=0; any same-cycle pop is ignored.
  - pc <= {redirect_pc[31:2], 2'b00} (feature off).
  - From FETCH with mem_ack in the same cycle: rdata discarded, next state FETCH at new pc.
  - From FETCH without mem_ack: stale_addr <= pc, next state DROP.
  - From HOLD: next state FETCH.
  - From DROP: pc updated, remain DROP.
- DROP: keep mem_req=1 at stale_addr. On mem_ack, discard data and go to FETCH at pc.
- Redirect to the current pc is legal and still flushes.
- Reset mid-request: state returns to FETCH at RESET_PC. Memory must itself abandon the request on the same synchronous reset. No ack is expected after reset.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Defined:
  - redirect with redirect_pc[1:0]!=0 sets fetch_fault=1 (sticky until rst) and flushes the FIFO.
  - If no request is outstanding, go to HALT; otherwise drain through DROP, then HALT.
  - HALT: mem_req=0, inst_valid=0, ignores further redirects.
  - inst_pc is irrelevant in HALT. The faulting PC is captured in an internal register readable by the bench hierarchically.
- Not defined: low bits are silently cleared, fetch_fault tied 0, HALT state absent.

Test Plan:
1. Reset, mem acks every cycle with rdata=addr^0xA5A5_0000, inst_ready=1 → mem_addr 0,4,8,… consecutive cycles; inst_pc 0,4,8 in order with matching inst; inst_valid high from cycle 2 onward.
2. inst_ready=0, ack every cycle → exactly 2 words buffered (pc 0,4), mem_req drops to 0 in HOLD. Raise inst_ready → pops 0 then 4, then a request at 8 in the cycle after the first pop.
3. Redirect to 0x100 while request at 0x8 is pending and ack delayed 3 cycles → mem_addr stays 0x8 until ack, data dropped, inst_valid=0 throughout, next mem_addr=0x100, first inst_pc=0x100.
4. Redirect to 0x40 in the same cycle as mem_ack for 0x10 with inst_ready=1 and count=1 → no 0x10 delivery, FIFO empty next cycle, next mem_addr=0x40.
5. pc=0xFFFF_FFFC acked → next mem_addr=0x0000_0000, inst_pc=0xFFFF_FFFC delivered.
6. Redirect to 0x102:
   - feature off → fetch from 0x100.
   - feature on → fetch_fault=1, mem_req=0 after drain, inst_valid=0, held until rst.

Source files
------------

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one-outstanding word reads to
// instruction memory over req/ack, buffers up to two words for decode and
// handles execute redirects. A redirect that arrives while a read is still
// outstanding parks the FSM in DROP until the stale ack has been absorbed.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (misaligned redirect traps
// into HALT with a sticky fetch_fault instead of clearing the low PC bits).
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        fetch_fault
);

`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {S_FETCH, S_HOLD, S_DROP, S_HALT} state_t;
`else
  typedef enum logic [1:0] {S_FETCH, S_HOLD, S_DROP} state_t;
`endif

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] stale_q, stale_d;

  // Two-entry FIFO: parallel PC/data arrays, 1-bit pointers, 2-bit count
  logic [31:0] fpc_q  [2];
  logic [31:0] fdat_q [2];
  logic        wr_q, rd_q;
  logic [1:0]  cnt_q, cnt_d;

  logic        redir, push, pop, misalign, fault_d;
  logic [31:0] tgt_pc;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic        fault_q;
  logic [31:0] fault_pc_q;
  // Once faulted the unit is dead until reset, so later redirects are ignored
  assign redir    = redirect_valid & ~fault_q;
  assign misalign = redir & (redirect_pc[1:0] != 2'b00);
  assign fault_d  = fault_q | misalign;
`else
  logic unused_lo;
  assign unused_lo = ^redirect_pc[1:0];
  assign redir     = redirect_valid;
  assign misalign  = 1'b0;
  assign fault_d   = 1'b0;
`endif

  assign tgt_pc     = {redirect_pc[31:2], 2'b00};
  assign inst_valid = (cnt_q != 2'd0);
  assign inst       = inst_valid ? fdat_q[rd_q] : NOP_INST;
  assign inst_pc    = inst_valid ? fpc_q[rd_q]  : 32'h0;
  assign mem_req    = (state_q == S_FETCH) || (state_q == S_DROP);
  assign mem_addr   = (state_q == S_DROP) ? stale_q : pc_q;

  // A redirect flushes the buffer and overrides both push and pop
  assign push  = (state_q == S_FETCH) & mem_ack & ~redir;
  assign pop   = inst_valid & inst_ready & ~redir;
  assign cnt_d = redir ? 2'd0 : (cnt_q + {1'b0, push} - {1'b0, pop});

  // Next-state, next-PC and stale-address selection
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    stale_d = stale_q;
    case (state_q)
      S_FETCH: begin
        if (redir) begin
          pc_d = tgt_pc;
          if (mem_ack) begin
`ifdef FETCH_MISALIGN_TRAP_EN
            state_d = misalign ? S_HALT : S_FETCH;
`else
            state_d = S_FETCH;
`endif
          end else begin
            stale_d = pc_q;
            state_d = S_DROP;
          end
        end else if (mem_ack) begin
          pc_d    = pc_q + 32'd4;
          state_d = (cnt_d == 2'd2) ? S_HOLD : S_FETCH;
        end
      end
      S_HOLD: begin
        if (redir) begin
          pc_d = tgt_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
          state_d = misalign ? S_HALT : S_FETCH;
`else
          state_d = S_FETCH;
`endif
        end else if (cnt_d != 2'd2) begin
          state_d = S_FETCH;
        end
      end
      S_DROP: begin
        if (redir) pc_d = tgt_pc;
        // Stale ack absorbed; a redirect landing on the same cycle is kept in pc_d
        if (mem_ack) begin
`ifdef FETCH_MISALIGN_TRAP_EN
          state_d = fault_d ? S_HALT : S_FETCH;
`else
          state_d = S_FETCH;
`endif
        end
      end
      default: ;
    endcase
  end

  // State, PC and FIFO registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      stale_q <= RESET_PC;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      stale_q <= stale_d;
      cnt_q   <= cnt_d;
      if (push) begin
        fpc_q[wr_q]  <= pc_q;
        fdat_q[wr_q] <= mem_rdata;
      end
      if (redir) begin
        wr_q <= 1'b0;
        rd_q <= 1'b0;
      end else begin
        if (push) wr_q <= ~wr_q;
        if (pop)  rd_q <= ~rd_q;
      end
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  // Sticky fault flag plus the offending redirect target
  always_ff @(posedge clk) begin
    if (rst) begin
      fault_q    <= 1'b0;
      fault_pc_q <= 32'h0;
    end else begin
      fault_q <= fault_d;
      if (misalign) fault_pc_q <= redirect_pc;
    end
  end
  assign fetch_fault = fault_q;
`else
  assign fetch_fault = fault_d;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Scoreboard bench for inst_fetch_unit: directed stimulus pushes expected
// {pc, inst} pairs; a monitor pops and compares on every accepted handshake.
// A behavioural memory answers with rdata = addr ^ 32'hA5A5_0000 after a
// programmable number of extra wait cycles.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        fetch_fault;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   lat    = 1000;
  int   wcnt   = 0;
  logic [31:0] req_addr;

  inst_fetch_unit dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc),
    .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic exp_push(input logic [31:0] p);
    exp_q.push_back('{pc: p, ins: p ^ 32'hA5A5_0000});
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 3; i++) begin
      neg();
      nxt();
    end
    chk(nm, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; lat = 1000;
    nxt(); nxt();
    neg();
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_inst", inst, 32'h0000_0013);
    chk("rst_inst_pc", inst_pc, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_fault", fetch_fault, 0);
    nxt();
  endtask

  // Memory model: acks after lat extra cycles, checks address stability
  initial begin
    mem_ack = 1'b0; mem_rdata = 32'h0; req_addr = 32'h0;
    forever begin
      @(negedge clk);
      if (rst || !mem_req) begin
        mem_ack = 1'b0; wcnt = 0;
      end else begin
        if (wcnt == 0) req_addr = mem_addr;
        else chk("addr_stable", mem_addr, req_addr);
        if (wcnt >= lat) begin
          mem_ack = 1'b1; mem_rdata = mem_addr ^ 32'hA5A5_0000; wcnt = 0;
        end else begin
          mem_ack = 1'b0; wcnt++;
        end
      end
    end
  end

  // Monitor: every accepted head is compared against the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && inst_valid && inst_ready && !redirect_valid) begin
        if (exp_q.size() == 0) begin
          errors++; checks++;
          $display("FAIL unexpected_pop: got pc %h inst %h expected none", inst_pc, inst);
        end else begin
          e = exp_q.pop_front();
          chk("sb_inst_pc", inst_pc, e.pc);
          chk("sb_inst", inst, e.ins);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // 1: streaming, ack every cycle, ready high
    do_reset();
    for (int i = 0; i < 8; i++) exp_push(32'(4 * i));
    rst = 1'b0; inst_ready = 1'b1; lat = 0;
    for (int i = 0; i < 8; i++) begin
      neg();
      chk("t1_mem_req", mem_req, 1);
      chk("t1_mem_addr", mem_addr, 32'(4 * i));
      chk("t1_inst_valid", inst_valid, (i == 0) ? 32'd0 : 32'd1);
      nxt();
    end
    lat = 1000;
    drain("t1_drained");

    // 2: backpressure fills FIFO, HOLD, then resume
    do_reset();
    exp_push(32'h0); exp_push(32'h4); exp_push(32'h8);
    rst = 1'b0; lat = 0;
    neg(); chk("t2_addr0", mem_addr, 32'h0); nxt();
    neg(); chk("t2_addr4", mem_addr, 32'h4); nxt();
    neg(); chk("t2_hold_req", mem_req, 0); chk("t2_hold_valid", inst_valid, 1);
    chk("t2_hold_pc", inst_pc, 32'h0); nxt();
    neg(); chk("t2_hold_req2", mem_req, 0); nxt();
    inst_ready = 1'b1;
    neg(); chk("t2_pop_req", mem_req, 0); nxt();
    neg(); chk("t2_resume_req", mem_req, 1); chk("t2_resume_addr", mem_addr, 32'h8); nxt();
    lat = 1000;
    drain("t2_drained");

    // 3: redirect with a delayed outstanding ack
    do_reset();
    exp_push(32'h0); exp_push(32'h100);
    rst = 1'b0; inst_ready = 1'b1; lat = 0;
    neg(); nxt();
    neg(); nxt();
    lat = 3; redirect_valid = 1'b1; redirect_pc = 32'h100;
    neg(); chk("t3_addr_r", mem_addr, 32'h8); nxt();
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      neg();
      chk("t3_drop_req", mem_req, 1);
      chk("t3_drop_addr", mem_addr, 32'h8);
      chk("t3_drop_valid", inst_valid, 0);
      nxt();
    end
    lat = 0;
    neg(); chk("t3_new_addr", mem_addr, 32'h100); chk("t3_new_req", mem_req, 1); nxt();
    lat = 1000;
    drain("t3_drained");

    // 4: redirect on the same cycle as an ack
    do_reset();
    exp_push(32'h0); exp_push(32'h4); exp_push(32'h8); exp_push(32'h40);
    rst = 1'b0; inst_ready = 1'b1; lat = 0;
    for (int i = 0; i < 4; i++) begin
      neg(); chk("t4_addr", mem_addr, 32'(4 * i)); nxt();
    end
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    neg(); chk("t4_addr10", mem_addr, 32'h10); chk("t4_cnt1", inst_valid, 1); nxt();
    redirect_valid = 1'b0;
    neg(); chk("t4_empty", inst_valid, 0); chk("t4_addr40", mem_addr, 32'h40); nxt();
    lat = 1000;
    drain("t4_drained");

    // 5: PC wraps past 0xFFFF_FFFC
    do_reset();
    exp_push(32'hFFFF_FFF8); exp_push(32'hFFFF_FFFC); exp_push(32'h0);
    rst = 1'b0; inst_ready = 1'b1; lat = 0;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    neg(); chk("t5_addr_first", mem_addr, 32'h0); nxt();
    redirect_valid = 1'b0;
    neg(); chk("t5_addr_f8", mem_addr, 32'hFFFF_FFF8); nxt();
    neg(); chk("t5_addr_fc", mem_addr, 32'hFFFF_FFFC); nxt();
    neg(); chk("t5_addr_wrap", mem_addr, 32'h0); nxt();
    lat = 1000;
    drain("t5_drained");

    // 6: misaligned redirect
    do_reset();
`ifndef FETCH_MISALIGN_TRAP_EN
    exp_push(32'h100);
`endif
    rst = 1'b0; inst_ready = 1'b1; lat = 0;
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    neg(); nxt();
    redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    neg(); chk("t6_fault", fetch_fault, 1); chk("t6_req", mem_req, 0);
    chk("t6_valid", inst_valid, 0); nxt();
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    neg(); chk("t6_halt_req", mem_req, 0); nxt();
    redirect_valid = 1'b0;
    neg(); chk("t6_halt_req2", mem_req, 0); chk("t6_fault2", fetch_fault, 1);
    chk("t6_halt_valid", inst_valid, 0); nxt();
    chk("t6_fault_pc", dut.fault_pc_q, 32'h102);
    drain("t6_drained");
`else
    neg(); chk("t6_addr", mem_addr, 32'h100); chk("t6_nofault", fetch_fault, 0); nxt();
    lat = 1000;
    drain("t6_drained");
`endif

    do_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
